tristate_bus_arbiter: RTL and testbench
=======================================

TRISTATE_BUS_ARBITER -- requirements
Module: tristate_bus_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one tristate net; legal range 2..8.
REQ-002 Parameter MAX_HOLD, default 8: maximum consecutive grant cycles while another requester waits; legal range >= 1.
REQ-003 Parameter TURN_CYC, default 1: dead cycles with all drivers off between owners; legal range >= 1.
REQ-004 Clocking and reset: one clock, clk; reset rst is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 req  input  NREQ  level request per requester; bit i held high while requester i wants the net.
REQ-008 en  output  NREQ  one-hot-or-zero enable; bit i drives requester i's bufif1 control.
REQ-009 owner  output  clog2(NREQ)  index of the current owner; valid only while busy = 1.
REQ-010 busy  output  1  high while any en bit is high.
REQ-011 timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Function
REQ-012 All outputs SHALL be registered; no combinational path from req to en.
REQ-013 en SHALL never have more than one bit set in any cycle.
REQ-014 The FSM SHALL have exactly three states: IDLE, GRANT and TURN.
REQ-015 IDLE: en = 0; if any req bit is sampled high, the FSM SHALL move to GRANT on that edge, with en set to the winner; latency is 1 clock from req sampled to en high.
REQ-016 The winner SHALL be chosen round-robin: search starts at index (last + 1) mod NREQ, where last is the most recent owner.
REQ-017 On each new grant, last SHALL update to the new owner.
REQ-018 GRANT: a hold counter SHALL count granted cycles, starting at 1 in the first grant cycle.
REQ-019 GRANT, release: if req[owner] is sampled low, the FSM SHALL move to TURN with en = 0 on the next cycle.
REQ-020 GRANT, timeout: if the hold counter equals MAX_HOLD and any other req bit is high, the FSM SHALL move to TURN with en = 0, and timeout SHALL pulse for exactly that first TURN cycle.
REQ-021 GRANT, extension: if the hold counter equals MAX_HOLD and no other req bit is high, the grant SHALL continue and the counter SHALL restart at 1, with no timeout.
REQ-022 If release and the timeout condition coincide, the block SHALL treat it as a release: no timeout pulse.
REQ-023 TURN: en = 0 for exactly TURN_CYC cycles.
REQ-024 Leaving TURN: the FSM SHALL go directly to GRANT, using the round-robin search on the req bits sampled in the last TURN cycle, or to IDLE if no req bit is high.
REQ-025 A requester whose grant was revoked by timeout SHALL be eligible again, but only in round-robin order.
REQ-026 A req bit that rises and falls entirely within TURN or IDLE without being sampled at a decision edge SHALL be ignored.
REQ-027 owner SHALL hold its last value while busy = 0.

Reset
REQ-028 While rst is sampled high, the block SHALL apply: state IDLE, en = 0, busy = 0, timeout = 0, owner = 0, hold counter = 0, last = NREQ-1 (so requester 0 has priority after reset).
REQ-029 rst asserted in GRANT or TURN SHALL force en = 0 on the next cycle, with no TURN sequence and no timeout pulse.
REQ-030 rst SHALL take priority over every state transition.

Verification (NREQ=4, MAX_HOLD=8, TURN_CYC=1)
REQ-031 After reset, req=4'b0101 at cycle 0 -> en=4'b0001 at cycle 1; then req[0] low at cycle 3 -> en=0 at cycle 4 and en=4'b0100 at cycle 5.
REQ-032 req=4'b1111 held constant -> grants in order 0,1,2,3,0; each grant lasts 8 cycles, followed by a 1-cycle gap with timeout=1.
REQ-033 req=4'b0010 alone, held 20 cycles -> en=4'b0010 continuously from cycle 1, timeout never asserted.
REQ-034 req[2] drops on the same edge the hold counter reaches 8 while req[3] is high -> TURN with timeout=0, then en=4'b1000.
REQ-035 rst pulsed mid-grant (en=4'b0100) -> en=0 the next cycle; with req=4'b0101 held, the first grant after reset is en=4'b0001.
REQ-036 Every test SHALL run a checker asserting $onehot0(en) every cycle and at least TURN_CYC zero cycles between differing nonzero en values.

Source files
------------

// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter for one shared tristate net. It produces registered bufif1
// enables, a bounded hold time while others wait, and enforced dead cycles between owners.
module tristate_bus_arbiter #(
    parameter int NREQ     = 4,
    parameter int MAX_HOLD = 8,
    parameter int TURN_CYC = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    output logic [NREQ-1:0]         en,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    busy,
    output logic                    timeout
);
    localparam int OW = $clog2(NREQ);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int TW = $clog2(TURN_CYC + 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);
    localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYC);

    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] en_d;
    logic [OW-1:0]   owner_d;
    logic            busy_d;
    logic            timeout_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [OW-1:0]   last_q, last_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic            start;
    logic [OW-1:0]   win;
    logic [NREQ-1:0] others;

    // Nearest requester after 'from', wrapping; 'from' itself is checked last.
    function automatic logic [OW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [OW-1:0]   from);
        logic [OW-1:0] w;
        int            idx;
        w = from;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(from) + k) % NREQ;
            if (r[idx]) w = OW'(idx);
        end
        return w;
    endfunction

    always_comb begin
        win       = rr_pick(req, last_q);
        others    = req & ~en;
        state_d   = state_q;
        en_d      = en;
        owner_d   = owner;
        busy_d    = busy;
        timeout_d = 1'b0;
        hold_d    = hold_q;
        last_d    = last_q;
        tcnt_d    = tcnt_q;
        start     = 1'b0;

        case (state_q)
            IDLE: start = |req;
            GRANT: begin
                if (!req[owner]) begin
                    state_d = TURN;
                    en_d    = '0;
                    busy_d  = 1'b0;
                    tcnt_d  = TW'(1);
                end else if (hold_q == HOLD_MAX) begin
                    // Revoke only when someone else is actually waiting.
                    if (|others) begin
                        state_d   = TURN;
                        en_d      = '0;
                        busy_d    = 1'b0;
                        tcnt_d    = TW'(1);
                        timeout_d = 1'b1;
                    end else begin
                        hold_d = HW'(1);
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            TURN: begin
                if (tcnt_q == TURN_LAST) begin
                    if (|req) start = 1'b1;
                    else      state_d = IDLE;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            state_d = GRANT;
            en_d    = NREQ'(1) << win;
            owner_d = win;
            last_d  = win;
            busy_d  = 1'b1;
            hold_d  = HW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            en      <= '0;
            owner   <= '0;
            busy    <= 1'b0;
            timeout <= 1'b0;
            hold_q  <= '0;
            last_q  <= OW'(NREQ - 1);
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            en      <= en_d;
            owner   <= owner_d;
            busy    <= busy_d;
            timeout <= timeout_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
            tcnt_q  <= tcnt_d;
        end
    end
endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Bench for tristate_bus_arbiter: directed scenarios plus randomized traffic
// checked against an integer reference model of the grant rules.
module tb_tristate_bus_arbiter;
    localparam int N  = 4;
    localparam int MH = 8;
    localparam int TC = 1;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] en;
    logic [1:0]   owner;
    logic         busy;
    logic         timeout;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    tristate_bus_arbiter #(.NREQ(N), .MAX_HOLD(MH), .TURN_CYC(TC)) dut (
        .clk(clk), .rst(rst), .req(req), .en(en),
        .owner(owner), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Reference model: current owner (-1 = none), remaining gap cycles, hold count.
    int   m_own, m_gap, m_hold, m_last, m_outown;
    logic m_to;

    function automatic int pick(input logic [N-1:0] r, input int from);
        for (int k = 1; k <= N; k++) begin
            if (r[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_en();
        logic [N-1:0] one;
        one = 1;
        return (m_own >= 0) ? (one << m_own) : '0;
    endfunction

    task automatic model_step(input logic [N-1:0] r, input logic rr);
        int           w;
        logic [N-1:0] mine;
        m_to = 1'b0;
        if (rr) begin
            m_own = -1; m_gap = 0; m_hold = 0; m_last = N - 1; m_outown = 0;
        end else if (m_own >= 0) begin
            mine = exp_en();
            if (!r[m_own]) begin
                m_own = -1; m_gap = TC;
            end else if (m_hold == MH) begin
                if ((r & ~mine) != '0) begin
                    m_own = -1; m_gap = TC; m_to = 1'b1;
                end else begin
                    m_hold = 1;
                end
            end else begin
                m_hold++;
            end
        end else begin
            if (m_gap > 0) m_gap--;
            if (m_gap == 0) begin
                w = pick(r, m_last);
                if (w >= 0) begin
                    m_own = w; m_last = w; m_hold = 1; m_outown = w;
                end
            end
        end
    endtask

    task automatic tick(input logic [N-1:0] r, input logic rr);
        req = r;
        rst = rr;
        @(posedge clk);
        model_step(r, rr);
        cyc++;
        #1;
    endtask

    // Monitor: at most one enable, and a dead gap between different owners.
    logic         mon_on = 1'b0;
    logic [N-1:0] prev_nz = '0;
    int           zeros = 0;
    always @(negedge clk) begin
        if (mon_on) begin
            checks++;
            if (!$onehot0(en)) begin
                errors++;
                $display("FAIL onehot0 cyc=%0d en=%b required at most one bit", cyc, en);
            end
            if (en != '0) begin
                if (prev_nz != '0 && en != prev_nz) begin
                    checks++;
                    if (zeros < TC) begin
                        errors++;
                        $display("FAIL turn_gap cyc=%0d zero_cycles=%0d required>=%0d", cyc, zeros, TC);
                    end
                end
                prev_nz = en;
                zeros = 0;
            end else begin
                zeros++;
            end
        end
    end

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(N'($urandom), 1'b1);
            checks++;
            if (en !== '0 || busy !== 1'b0 || timeout !== 1'b0 || owner !== 2'd0) begin
                errors++;
                $display("FAIL reset_state en=%b busy=%b timeout=%b owner=%0d required 0/0/0/0",
                         en, busy, timeout, owner);
            end
        end
        mon_on = 1'b1;
    endtask

    task automatic test_basic_release();
        logic [N-1:0] seq_req [5] = '{4'b0101, 4'b0101, 4'b0101, 4'b0100, 4'b0100};
        logic [N-1:0] seq_en  [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0100};
        tick('0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick(seq_req[i], 1'b0);
            checks++;
            if (en !== seq_en[i]) begin
                errors++;
                $display("FAIL basic_release cycle=%0d en=%b required=%b", i + 1, en, seq_en[i]);
            end
        end
        checks++;
        if (owner !== 2'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_owner owner=%0d busy=%b required 2/1", owner, busy);
        end
    endtask

    task automatic test_round_robin_timeout();
        logic [N-1:0] want;
        logic         want_to;
        int           g, pos;
        tick('0, 1'b1);
        for (int c = 1; c <= 5 * (MH + TC); c++) begin
            tick(4'b1111, 1'b0);
            g   = (c - 1) / (MH + TC);
            pos = (c - 1) % (MH + TC);
            want    = (pos < MH) ? N'(1 << (g % N)) : '0;
            want_to = (pos == MH);
            checks++;
            if (en !== want || timeout !== want_to) begin
                errors++;
                $display("FAIL rr_timeout cycle=%0d en=%b timeout=%b required en=%b timeout=%b",
                         c, en, timeout, want, want_to);
            end
        end
    endtask

    task automatic test_extension();
        tick('0, 1'b1);
        for (int c = 1; c <= 20; c++) begin
            tick(4'b0010, 1'b0);
            checks++;
            if (en !== 4'b0010 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL extension cycle=%0d en=%b timeout=%b required en=0010 timeout=0",
                         c, en, timeout);
            end
        end
    endtask

    task automatic test_release_at_limit();
        tick('0, 1'b1);
        for (int c = 1; c <= MH; c++) tick(4'b1100, 1'b0);
        checks++;
        if (en !== 4'b0100) begin
            errors++;
            $display("FAIL limit_pre en=%b required=0100", en);
        end
        tick(4'b1000, 1'b0);
        checks++;
        if (en !== 4'b0000 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL limit_turn en=%b timeout=%b required en=0000 timeout=0", en, timeout);
        end
        tick(4'b1000, 1'b0);
        checks++;
        if (en !== 4'b1000) begin
            errors++;
            $display("FAIL limit_next en=%b required=1000", en);
        end
    endtask

    task automatic test_reset_mid_grant();
        tick('0, 1'b1);
        for (int c = 0; c < 3; c++) tick(4'b0100, 1'b0);
        checks++;
        if (en !== 4'b0100) begin
            errors++;
            $display("FAIL midrst_pre en=%b required=0100", en);
        end
        tick(4'b0101, 1'b1);
        checks++;
        if (en !== '0 || busy !== 1'b0 || timeout !== 1'b0 || owner !== 2'd0) begin
            errors++;
            $display("FAIL midrst_clear en=%b busy=%b timeout=%b owner=%0d required 0/0/0/0",
                     en, busy, timeout, owner);
        end
        tick(4'b0101, 1'b0);
        checks++;
        if (en !== 4'b0001) begin
            errors++;
            $display("FAIL midrst_first en=%b required=0001", en);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] r;
        logic         rr;
        tick('0, 1'b1);
        r = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) if ($urandom_range(7) == 0) r[b] = ~r[b];
            rr = ($urandom_range(299) == 0);
            tick(r, rr);
            checks++;
            if (en !== exp_en()) begin
                errors++;
                $display("FAIL rand_en cyc=%0d en=%b required=%b", cyc, en, exp_en());
            end
            checks++;
            if (busy !== (m_own >= 0)) begin
                errors++;
                $display("FAIL rand_busy cyc=%0d busy=%b required=%b", cyc, busy, (m_own >= 0));
            end
            checks++;
            if (timeout !== m_to) begin
                errors++;
                $display("FAIL rand_timeout cyc=%0d timeout=%b required=%b", cyc, timeout, m_to);
            end
            checks++;
            if (int'(owner) !== m_outown) begin
                errors++;
                $display("FAIL rand_owner cyc=%0d owner=%0d required=%0d", cyc, owner, m_outown);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        m_own = -1; m_gap = 0; m_hold = 0; m_last = N - 1; m_outown = 0; m_to = 1'b0;
        test_reset();
        test_basic_release();
        test_round_robin_timeout();
        test_extension();
        test_release_at_limit();
        test_reset_mid_grant();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
